cache_axi_master: RTL and testbench
===================================

CACHE_AXI_MASTER -- requirements
Module: cache_axi_master
Burst engine for one cache. It writes back a dirty line and then refills it over AXI4. It exports cache_state_t so the external request arbiter can grant the bus while state != IDLE.

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 128, meaning 32-bit words per cache line (power of two, 2..256).
REQ-002 SHALL have parameter AXI_ID, default 0, driven on awid/arid.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle request; sampled only in IDLE.
REQ-006 writeback  in  1  with start, 1 = write back line before refill.
REQ-007 wb_addr  in  32  writeback line base address, latched on start.
REQ-008 refill_addr  in  32  refill line base address, latched on start.
REQ-009 wb_rd_idx  out  $clog2(LINE_WORDS)  word index into the cache data array; combinational read.
REQ-010 wb_rd_data  in  32  cache word at wb_rd_idx, same cycle.
REQ-011 rf_we  out  1  refill word write strobe.
REQ-012 rf_idx  out  $clog2(LINE_WORDS)  refill word index.
REQ-013 rf_data  out  32  refill word.
REQ-014 done  out  1  one-cycle pulse, whole transaction complete.
REQ-015 error  out  1  sticky per transaction: any non-OKAY resp or burst-length mismatch; cleared on next accepted start.
REQ-016 state  out  cache_state_t  current FSM state, consumed by the arbiter.
REQ-017 m_axi  axi_if.master  full AXI4 master port.

Function
REQ-018 FSM states SHALL be IDLE, SENDING_WRITE_REQ, SENDING_WRITE_DATA, WAITING_WRITE_RES, SENDING_READ_REQ, RECEIVING_READ_DATA.
REQ-019 IDLE + start: go to SENDING_WRITE_REQ if writeback=1, else SENDING_READ_REQ; start in any other state SHALL be ignored.
REQ-020 SENDING_WRITE_REQ: awvalid=1, awaddr=latched wb_addr, awlen=LINE_WORDS-1, awsize=2, awburst=INCR; on awvalid&awready go to SENDING_WRITE_DATA with beat counter=0.
REQ-021 SENDING_WRITE_DATA: wvalid=1, wdata=wb_rd_data, wb_rd_idx=counter, wstrb=4'hF, wlast=(counter==LINE_WORDS-1); each wvalid&wready SHALL increment counter; last handshake goes to WAITING_WRITE_RES.
REQ-022 wdata/wstrb/wlast SHALL stay stable while wvalid&!wready.
REQ-023 WAITING_WRITE_RES: bready=1; on bvalid go to SENDING_READ_REQ; bresp!=0 sets error.
REQ-024 SENDING_READ_REQ: arvalid=1, araddr=latched refill_addr, arlen=LINE_WORDS-1, arsize=2, arburst=INCR; on arready go to RECEIVING_READ_DATA, counter=0.
REQ-025 RECEIVING_READ_DATA: rready=1; each rvalid gives combinational rf_we=1, rf_idx=counter, rf_data=rdata, then counter increments.
REQ-026 rvalid&rlast SHALL return to IDLE and assert done (registered) in the following cycle.
REQ-027 error SHALL be set by: rresp!=0; rlast with counter!=LINE_WORDS-1; or a beat beyond LINE_WORDS-1 without rlast. Such beats SHALL NOT assert rf_we.
REQ-028 Outside its owning state every valid/ready output SHALL be 0 and all other m_axi outputs 0.
REQ-029 valid SHALL never depend combinationally on the matching ready; once asserted it holds until handshake.
REQ-030 Counter SHALL be $clog2(LINE_WORDS)+1 bits; no wrap within a burst.
REQ-031 Write-back to refill latency: SENDING_READ_REQ entered the cycle after the bvalid handshake. No idle cycle between write and read phases.

Reset
REQ-032 rst_n low SHALL immediately force state=IDLE and counter=0. It SHALL also zero done, error, rf_we and all m_axi valid/ready outputs, including mid-burst.
REQ-033 Latched addresses SHALL reset to 0; after release the first start is accepted on the next edge.

Structure
REQ-034 cache_state_t SHALL be reused from holy_core_pkg. AXI burst/size encodings (INCR=2'b01, SIZE_4B=3'b010) and the OKAY resp code SHALL be added there as constants.
REQ-035 Single flat module with one FSM and one beat counter; no sub-module.

Verification
REQ-036 LINE_WORDS=4, start, writeback=0, refill_addr=0x100, slave returns 4 beats with rlast on 4th -> arlen=3, araddr=0x100, rf_idx 0..3 written, done one cycle after rlast, error=0.
REQ-037 writeback=1, wb_addr=0x200, awready delayed 3 cycles, wready toggled -> 4 W beats in index order, wlast only on 4th, wdata stable under stall, then AR issued.
REQ-038 bresp=2'b10 -> error=1, refill still completes, done pulses; next start clears error.
REQ-039 rlast on beat 2 of 4 -> IDLE, done, error=1.
REQ-040 rst_n low during SENDING_WRITE_DATA beat 2 -> same-cycle wvalid=0, state=IDLE; a new start after release completes cleanly.
REQ-041 start pulsed while RECEIVING_READ_DATA -> ignored; exactly one done.

Source files
------------

// File: rtl/holy_core_pkg.sv
// Shared core types: cache burst-engine states and the AXI4 encodings it drives.
package holy_core_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SENDING_WRITE_REQ,
      SENDING_WRITE_DATA,
      WAITING_WRITE_RES,
      SENDING_READ_REQ,
      RECEIVING_READ_DATA
   } cache_state_t;

   localparam int         AXI_ID_W       = 4;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle, 32-bit address and data, shared by the cache master and its slave.
interface axi_if;

   logic [holy_core_pkg::AXI_ID_W-1:0] awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic [3:0]  awqos;
   logic        awvalid;
   logic        awready;

   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic [holy_core_pkg::AXI_ID_W-1:0] bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   logic [holy_core_pkg::AXI_ID_W-1:0] arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic [3:0]  arqos;
   logic        arvalid;
   logic        arready;

   logic [holy_core_pkg::AXI_ID_W-1:0] rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      output wdata, wstrb, wlast, wvalid, bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      output rready,
      input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      input  wdata, wstrb, wlast, wvalid, bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      input  rready,
      output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );

endinterface

// File: rtl/cache_axi_master.sv
// Cache line burst engine: optional AXI4 write-back of a dirty line, then refill.
module cache_axi_master
   import holy_core_pkg::*;
#(
   parameter int                  LINE_WORDS = 128,
   parameter logic [AXI_ID_W-1:0] AXI_ID     = '0,
   localparam int                 IW         = $clog2(LINE_WORDS),
   localparam int                 CW         = IW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          writeback,
   input  logic [31:0]   wb_addr,
   input  logic [31:0]   refill_addr,
   output logic [IW-1:0] wb_rd_idx,
   input  logic [31:0]   wb_rd_data,
   output logic          rf_we,
   output logic [IW-1:0] rf_idx,
   output logic [31:0]   rf_data,
   output logic          done,
   output logic          error,
   output cache_state_t  state,
   axi_if.master         m_axi
);

   localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);
   localparam logic [CW-1:0] OVER_BEAT = CW'(LINE_WORDS);
   localparam logic [7:0]    BURST_LEN = 8'(LINE_WORDS - 1);

   cache_state_t  state_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   wb_addr_q;
   logic [31:0]   rf_addr_q;
   logic          done_q;
   logic          error_q;
   logic          r_bad;

   // A read beat is bad on a slave error, an early rlast, or when it lies past the line.
   assign r_bad = (m_axi.rresp != AXI_RESP_OKAY) ||
                  (m_axi.rlast && (cnt_q != LAST_BEAT)) ||
                  (cnt_q > LAST_BEAT);

   assign state = state_q;
   assign done  = done_q;
   assign error = error_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wb_addr_q <= '0;
         rf_addr_q <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every branch sees the pre-edge values.
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               error_q   <= 1'b0;
               wb_addr_q <= wb_addr;
               rf_addr_q <= refill_addr;
               cnt_q     <= '0;
               state_q   <= writeback ? SENDING_WRITE_REQ : SENDING_READ_REQ;
            end
            SENDING_WRITE_REQ: if (m_axi.awready) begin
               cnt_q   <= '0;
               state_q <= SENDING_WRITE_DATA;
            end
            SENDING_WRITE_DATA: if (m_axi.wready) begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_BEAT) state_q <= WAITING_WRITE_RES;
            end
            WAITING_WRITE_RES: if (m_axi.bvalid) begin
               if (m_axi.bresp != AXI_RESP_OKAY) error_q <= 1'b1;
               state_q <= SENDING_READ_REQ;
            end
            SENDING_READ_REQ: if (m_axi.arready) begin
               cnt_q   <= '0;
               state_q <= RECEIVING_READ_DATA;
            end
            RECEIVING_READ_DATA: if (m_axi.rvalid) begin
               if (r_bad) error_q <= 1'b1;
               if (cnt_q != OVER_BEAT) cnt_q <= cnt_q + 1'b1;
               if (m_axi.rlast) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      // NOTE: every output takes a default first, so no path through the case infers a latch.
      m_axi.awid    = '0;
      m_axi.awaddr  = '0;
      m_axi.awlen   = '0;
      m_axi.awsize  = '0;
      m_axi.awburst = '0;
      m_axi.awlock  = 1'b0;
      m_axi.awcache = '0;
      m_axi.awprot  = '0;
      m_axi.awqos   = '0;
      m_axi.awvalid = 1'b0;
      m_axi.wdata   = '0;
      m_axi.wstrb   = '0;
      m_axi.wlast   = 1'b0;
      m_axi.wvalid  = 1'b0;
      m_axi.bready  = 1'b0;
      m_axi.arid    = '0;
      m_axi.araddr  = '0;
      m_axi.arlen   = '0;
      m_axi.arsize  = '0;
      m_axi.arburst = '0;
      m_axi.arlock  = 1'b0;
      m_axi.arcache = '0;
      m_axi.arprot  = '0;
      m_axi.arqos   = '0;
      m_axi.arvalid = 1'b0;
      m_axi.rready  = 1'b0;
      wb_rd_idx     = '0;
      rf_we         = 1'b0;
      rf_idx        = '0;
      rf_data       = '0;
      case (state_q)
         SENDING_WRITE_REQ: begin
            m_axi.awvalid = 1'b1;
            m_axi.awid    = AXI_ID;
            m_axi.awaddr  = wb_addr_q;
            m_axi.awlen   = BURST_LEN;
            m_axi.awsize  = AXI_SIZE_4B;
            m_axi.awburst = AXI_BURST_INCR;
         end
         SENDING_WRITE_DATA: begin
            // The index only moves on a handshake, so wdata holds steady through a stall.
            wb_rd_idx    = cnt_q[IW-1:0];
            m_axi.wvalid = 1'b1;
            m_axi.wdata  = wb_rd_data;
            m_axi.wstrb  = 4'hF;
            m_axi.wlast  = (cnt_q == LAST_BEAT);
         end
         WAITING_WRITE_RES: m_axi.bready = 1'b1;
         SENDING_READ_REQ: begin
            m_axi.arvalid = 1'b1;
            m_axi.arid    = AXI_ID;
            m_axi.araddr  = rf_addr_q;
            m_axi.arlen   = BURST_LEN;
            m_axi.arsize  = AXI_SIZE_4B;
            m_axi.arburst = AXI_BURST_INCR;
         end
         RECEIVING_READ_DATA: begin
            m_axi.rready = 1'b1;
            rf_idx       = cnt_q[IW-1:0];
            if (m_axi.rvalid && !r_bad) begin
               rf_we   = 1'b1;
               rf_data = m_axi.rdata;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_axi_master.sv
// Randomized bench for cache_axi_master: the bench plays the AXI slave and the cache array.
module tb_cache_axi_master;
   import holy_core_pkg::*;

   localparam int LW = 4;
   localparam int IW = $clog2(LW);
   localparam logic [AXI_ID_W-1:0] ID = 4'h5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, writeback;
   logic [31:0]   wb_addr, refill_addr;
   logic [IW-1:0] wb_rd_idx;
   logic [31:0]   wb_rd_data;
   logic          rf_we;
   logic [IW-1:0] rf_idx;
   logic [31:0]   rf_data;
   logic          done, error;
   cache_state_t  dut_state;
   logic [31:0]   cache_mem [LW];
   int            errs = 0;
   int            checks = 0;

   axi_if intf ();

   cache_axi_master #(.LINE_WORDS(LW), .AXI_ID(ID)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .writeback(writeback),
      .wb_addr(wb_addr), .refill_addr(refill_addr),
      .wb_rd_idx(wb_rd_idx), .wb_rd_data(wb_rd_data),
      .rf_we(rf_we), .rf_idx(rf_idx), .rf_data(rf_data),
      .done(done), .error(error), .state(dut_state), .m_axi(intf)
   );

   always #5 clk = ~clk;
   assign wb_rd_data = cache_mem[wb_rd_idx];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic slave_idle();
      intf.awready = 0; intf.wready = 0; intf.bvalid = 0; intf.bresp = 0; intf.bid = '0;
      intf.arready = 0; intf.rvalid = 0; intf.rdata = 0; intf.rresp = 0; intf.rlast = 0;
      intf.rid = '0;
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic run_txn(input bit wb, input logic [31:0] wba, input logic [31:0] rfa,
                          input int aw_dly, input logic [1:0] bresp_v,
                          input int rlast_at, input int rbad_beat, input bit poke_start);
      int   beats, guard;
      bit   hs, exp_we, exp_err;
      logic [31:0] rd;
      for (int i = 0; i < LW; i++) cache_mem[i] = $urandom;
      exp_err = (wb && bresp_v != AXI_RESP_OKAY) || (rlast_at != LW - 1) || (rbad_beat >= 0);
      start = 1; writeback = wb; wb_addr = wba; refill_addr = rfa;
      @(negedge clk);
      start = 0; writeback = 0; wb_addr = $urandom; refill_addr = $urandom;
      check("err_clr", error, 0);
      if (wb) begin
         check("st_awreq", dut_state, SENDING_WRITE_REQ);
         for (int d = 0; d < aw_dly; d++) begin
            check("awvalid_hold", intf.awvalid, 1);
            @(negedge clk);
         end
         check("awvalid", intf.awvalid, 1);
         check("awaddr", intf.awaddr, wba);
         check("awlen", intf.awlen, LW - 1);
         check("awsize", intf.awsize, 3'b010);
         check("awburst", intf.awburst, 2'b01);
         check("awid", intf.awid, ID);
         intf.awready = 1;
         @(negedge clk);
         intf.awready = 0;
         beats = 0; guard = 0;
         while (beats < LW && guard < 200) begin
            check("wvalid", intf.wvalid, 1);
            check("wdata", intf.wdata, cache_mem[beats]);
            check("wlast", intf.wlast, beats == LW - 1);
            check("wstrb", intf.wstrb, 4'hF);
            hs = 1'($urandom_range(0, 1));
            intf.wready = hs;
            @(negedge clk);
            if (hs) beats++;
            guard++;
         end
         intf.wready = 0;
         check("w_beats", beats, LW);
         check("st_bwait", dut_state, WAITING_WRITE_RES);
         check("bready", intf.bready, 1);
         check("wvalid_off", intf.wvalid, 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         intf.bvalid = 1; intf.bresp = bresp_v;
         @(negedge clk);
         intf.bvalid = 0; intf.bresp = 0;
      end
      check("st_arreq", dut_state, SENDING_READ_REQ);
      repeat ($urandom_range(0, 2)) begin
         check("arvalid_hold", intf.arvalid, 1);
         @(negedge clk);
      end
      check("arvalid", intf.arvalid, 1);
      check("araddr", intf.araddr, rfa);
      check("arlen", intf.arlen, LW - 1);
      check("arsize", intf.arsize, 3'b010);
      check("arburst", intf.arburst, 2'b01);
      check("arid", intf.arid, ID);
      check("awvalid_off", intf.awvalid, 0);
      intf.arready = 1;
      @(negedge clk);
      intf.arready = 0;
      check("st_rdata", dut_state, RECEIVING_READ_DATA);
      check("rready", intf.rready, 1);
      for (int i = 0; i <= rlast_at; i++) begin
         if ($urandom_range(0, 2) == 0 || (poke_start && i == 1)) begin
            if (poke_start && i == 1) begin start = 1; writeback = 1; end
            #1 check("rf_we_gap", rf_we, 0);
            @(negedge clk);
            start = 0; writeback = 0;
            check("st_rdata_hold", dut_state, RECEIVING_READ_DATA);
         end
         exp_we = (i <= LW - 1) && (i != rbad_beat) && !(i == rlast_at && i != LW - 1);
         rd = $urandom;
         intf.rvalid = 1; intf.rdata = rd; intf.rlast = (i == rlast_at);
         intf.rresp = (i == rbad_beat) ? 2'b10 : 2'b00;
         #1;
         check("rf_we", rf_we, exp_we);
         if (exp_we) begin
            check("rf_idx", rf_idx, i);
            check("rf_data", rf_data, rd);
         end
         @(negedge clk);
         intf.rvalid = 0; intf.rlast = 0; intf.rresp = 0;
         if (i < rlast_at) check("done_early", done, 0);
      end
      check("done", done, 1);
      check("st_idle", dut_state, IDLE);
      check("error", error, exp_err);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("done_once", done, 0);
         check("error_sticky", error, exp_err);
      end
   endtask

   initial begin
      rst_n = 0; start = 0; writeback = 0; wb_addr = 0; refill_addr = 0;
      for (int i = 0; i < LW; i++) cache_mem[i] = 0;
      slave_idle();
      repeat (2) @(negedge clk);
      check("rst_state", dut_state, IDLE);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_valids", {intf.awvalid, intf.wvalid, intf.bready, intf.arvalid, intf.rready}, 0);
      check("rst_rf_we", rf_we, 0);
      rst_n = 1;

      run_txn(0, 32'h0,   32'h100, 0, 2'b00, LW - 1, -1, 0);
      run_txn(1, 32'h200, 32'h300, 3, 2'b00, LW - 1, -1, 0);
      run_txn(1, 32'h400, 32'h500, 1, 2'b10, LW - 1, -1, 0);
      run_txn(0, 32'h0,   32'h600, 0, 2'b00, 1,      -1, 0);
      run_txn(0, 32'h0,   32'h700, 0, 2'b00, LW - 1,  2, 0);
      run_txn(0, 32'h0,   32'h800, 0, 2'b00, LW,     -1, 0);
      run_txn(0, 32'h0,   32'h900, 0, 2'b00, LW - 1, -1, 1);

      // Reset while the third write beat is on the bus.
      for (int i = 0; i < LW; i++) cache_mem[i] = $urandom;
      start = 1; writeback = 1; wb_addr = 32'hA00; refill_addr = 32'hB00;
      @(negedge clk);
      start = 0; writeback = 0;
      intf.awready = 1;
      @(negedge clk);
      intf.awready = 0; intf.wready = 1;
      repeat (2) @(negedge clk);
      check("mid_wvalid", intf.wvalid, 1);
      check("mid_wdata", intf.wdata, cache_mem[2]);
      rst_n = 0;
      #1;
      check("rst_mid_wvalid", intf.wvalid, 0);
      check("rst_mid_state", dut_state, IDLE);
      check("rst_mid_done", done, 0);
      @(negedge clk);
      intf.wready = 0; rst_n = 1;
      run_txn(1, 32'hC00, 32'hD00, 2, 2'b00, LW - 1, -1, 0);

      for (int n = 0; n < 8; n++) begin
         logic [1:0] br;
         br = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
         run_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFF0, $urandom & 32'hFFFF_FFF0,
                 $urandom_range(0, 3), br, LW - 1, -1, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
